// File: rtl/dct_pkg.sv
// dct_pkg: coefficient indices, coefficient values and product width offset for the DCT multiplier
package dct_pkg;
  typedef enum logic [2:0] {C64, C60, C56, C45, C36, C24, C12, CBYP} coeff_e;
  localparam int COEFF_VAL [7] = '{64, 60, 56, 45, 36, 24, 12};
  localparam int OUT_OFS = 7;
endpackage

// File: rtl/dct_cmult_pipe_if.sv
// dct_cmult_pipe_if: shared valid/ready handshake plus per-lane operand and result buses
interface dct_cmult_pipe_if
  import dct_pkg::*;
#(
  parameter int SIZE  = 8,
  parameter int LANES = 8
);
  localparam int OUT_W = SIZE + OUT_OFS;
  logic                   in_valid;
  logic                   in_ready;
  logic [LANES*SIZE-1:0]  mcand;
  logic [LANES*3-1:0]     coeff_sel;
  logic [LANES-1:0]       coeff_neg;
  logic                   approx_en;
  logic                   out_valid;
  logic                   out_ready;
  logic [LANES*OUT_W-1:0] result;
  modport master (
    output in_valid, mcand, coeff_sel, coeff_neg, approx_en, out_ready,
    input  in_ready, out_valid, result
  );
  modport slave (
    input  in_valid, mcand, coeff_sel, coeff_neg, approx_en, out_ready,
    output in_ready, out_valid, result
  );
endinterface

// File: rtl/dct_cmult_lane.sv
// dct_cmult_lane: one shift-add constant multiplier lane; S1 picks terms, S2 pair sums, S3 final sum and negate
module dct_cmult_lane
  import dct_pkg::*;
#(
  parameter int SIZE        = 8,
  parameter int APPROX_BITS = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    ld1_i,
  input  logic                    ld2_i,
  input  logic                    ld3_i,
  input  logic                    approx_i,
  input  logic [SIZE-1:0]         mcand_i,
  input  coeff_e                  sel_i,
  input  logic                    neg_i,
  output logic [SIZE+OUT_OFS-1:0] result_o
);
  localparam int W = SIZE + OUT_OFS;
  localparam logic [W-1:0] LO_MASK = (W'(1) << APPROX_BITS) - W'(1);
  // approximate mode ORs the low bits and injects no carry above them
  function automatic logic [W-1:0] add_f(input logic [W-1:0] x, input logic [W-1:0] y,
                                         input logic cin, input logic ap);
    return (ap && APPROX_BITS != 0)
      ? ((((x >> APPROX_BITS) + (y >> APPROX_BITS)) << APPROX_BITS) | ((x | y) & LO_MASK))
      : x + y + W'(cin);
  endfunction
  logic [W-1:0] m, a_d, b_d, c_d, d_d, a_q, b_q, c_q, d_q, p_d, q_d, p_q, q_q, s3, r_d, r_q;
  logic sub_d, sub_q, neg1_q, neg2_q, ap1_q, ap2_q;
  assign m = {{OUT_OFS{mcand_i[SIZE-1]}}, mcand_i};
  always_comb begin
    a_d = (sel_i == C64 || sel_i == C60 || sel_i == C56) ? m << 6 :
          (sel_i == C36 || sel_i == C12) ? m << 2 :
          (sel_i == C24) ? m << 3 : m;
    b_d = (sel_i == C60 || sel_i == C45) ? m << 2 :
          (sel_i == C56 || sel_i == C12) ? m << 3 :
          (sel_i == C36) ? m << 5 :
          (sel_i == C24) ? m << 4 : '0;
    c_d = (sel_i == C45) ? m << 3 : '0;
    d_d = (sel_i == C45) ? m << 5 : '0;
    sub_d = sel_i == C60 || sel_i == C56;
  end
  assign p_d = add_f(a_q, sub_q ? ~b_q : b_q, sub_q, ap1_q);
  assign q_d = add_f(c_q, d_q, 1'b0, ap1_q);
  assign s3  = add_f(p_q, q_q, 1'b0, ap2_q);
  assign r_d = neg2_q ? ~s3 + W'(1) : s3;
  always_ff @(posedge clk) begin
    if (rst) begin
      {a_q, b_q, c_q, d_q, sub_q, neg1_q, ap1_q} <= '0;
      {p_q, q_q, neg2_q, ap2_q} <= '0;
      r_q <= '0;
    end else begin
      if (ld1_i) {a_q, b_q, c_q, d_q, sub_q, neg1_q, ap1_q} <= {a_d, b_d, c_d, d_d, sub_d, neg_i, approx_i};
      if (ld2_i) {p_q, q_q, neg2_q, ap2_q} <= {p_d, q_d, neg1_q, ap1_q};
      if (ld3_i) r_q <= r_d;
    end
  end
  assign result_o = r_q;
endmodule

// File: rtl/dct_cmult_pipe.sv
// dct_cmult_pipe: LANES-wide 3-stage constant multiplier sharing one valid/ready handshake
module dct_cmult_pipe
  import dct_pkg::*;
#(
  parameter int SIZE        = 8,
  parameter int LANES       = 8,
  parameter int APPROX_BITS = 0
) (
  input logic             clk,
  input logic             rst,
  dct_cmult_pipe_if.slave bus
);
  localparam int OUT_W = SIZE + OUT_OFS;
  logic v1_q, v2_q, v3_q, v1_d, v2_d, v3_d, en1, en2, en3;
  // a stage loads when empty or when the stage after it moves on
  always_comb begin
    en3  = !v3_q || bus.out_ready;
    en2  = !v2_q || en3;
    en1  = !v1_q || en2;
    v1_d = en1 ? bus.in_valid : v1_q;
    v2_d = en2 ? v1_q : v2_q;
    v3_d = en3 ? v2_q : v3_q;
  end
  assign bus.in_ready  = en1 && !rst;
  assign bus.out_valid = v3_q;
  always_ff @(posedge clk) begin
    if (rst) {v1_q, v2_q, v3_q} <= '0;
    else {v1_q, v2_q, v3_q} <= {v1_d, v2_d, v3_d};
  end
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    dct_cmult_lane #(.SIZE(SIZE), .APPROX_BITS(APPROX_BITS)) u_lane (
      .clk     (clk),
      .rst     (rst),
      .ld1_i   (en1 && bus.in_valid),
      .ld2_i   (en2 && v1_q),
      .ld3_i   (en3 && v2_q),
      .approx_i(bus.approx_en),
      .mcand_i (bus.mcand[i*SIZE +: SIZE]),
      .sel_i   (coeff_e'(bus.coeff_sel[i*3 +: 3])),
      .neg_i   (bus.coeff_neg[i]),
      .result_o(bus.result[i*OUT_W +: OUT_W])
    );
  end
endmodule

// File: doc/dct_cmult_pipe.md
DCT_CMULT_PIPE -- requirements
Module: dct_cmult_pipe

Parameters
REQ-001 SHALL have parameter SIZE, default 8: signed multiplicand width per lane.
REQ-002 SHALL have parameter LANES, default 8: independent multiplier lanes sharing one handshake.
REQ-003 SHALL have parameter APPROX_BITS, default 0: count of low adder bits approximated when approx_en=1; legal range 0..SIZE.
REQ-004 SHALL define localparam OUT_W = SIZE+7: signed product width per lane.

Interface
REQ-005 SHALL have port clk, input, 1: sole clock; all state changes on rising edge.
REQ-006 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-007 SHALL have port in_valid, input, 1: input beat valid.
REQ-008 SHALL have port in_ready, output, 1: block accepts a beat this cycle.
REQ-009 SHALL have port mcand, input, LANES*SIZE: signed multiplicands, lane i at bits [i*SIZE +: SIZE].
REQ-010 SHALL have port coeff_sel, input, LANES*3: per-lane index; 0..6 = 64,60,56,45,36,24,12; 7 = bypass.
REQ-011 SHALL have port coeff_neg, input, LANES: per-lane negate of the product.
REQ-012 SHALL have port approx_en, input, 1: captured per beat, applies to all lanes.
REQ-013 SHALL have port out_valid, output, 1: result beat valid.
REQ-014 SHALL have port out_ready, input, 1: downstream accepts the result.
REQ-015 SHALL have port result, output, LANES*OUT_W: signed products, lane i at bits [i*OUT_W +: OUT_W].

Function
REQ-016 SHALL form each product from fixed shift-add terms only, with no multiplier operator: 64=m<<6; 60=(m<<6)-(m<<2); 56=(m<<6)-(m<<3); 45=((m)+(m<<2))+((m<<3)+(m<<5)); 36=(m<<2)+(m<<5); 24=(m<<3)+(m<<4); 12=(m<<2)+(m<<3).
REQ-017 SHALL output bypass (sel=7) as mcand sign-extended to OUT_W, with coeff_neg still applied.
REQ-018 SHALL sign-extend all operands to OUT_W before addition; no result overflows for any SIZE-bit input.
REQ-019 SHALL implement subtraction as addition of the inverted operand with carry-in 1.
REQ-020 SHALL implement coeff_neg as a two's-complement negate in the final stage; no saturation.
REQ-021 SHALL, when approx_en=1, compute the low APPROX_BITS bits of every adder as bitwise OR of its operands, with zero carry into bit APPROX_BITS; the negate stage is always exact.
REQ-022 SHALL give exact results when approx_en=0 or APPROX_BITS=0.
REQ-023 SHALL use a 3-stage pipeline: S1 registers inputs and shifted terms; S2 performs first-level adds (both pair sums for 45); S3 performs the final add (zero operand for two-term coefficients) and the negate.
REQ-024 SHALL have latency of exactly 3 cycles from an accepted beat to out_valid when out_ready is held high.
REQ-025 SHALL sustain throughput of 1 beat/cycle while out_ready=1.
REQ-026 SHALL implement per-stage valid bits and advance stage k when it is empty or stage k+1 advances; in_ready = S1 empty or S1 advancing; no combinational path from in_valid to in_ready.
REQ-027 SHALL hold result and out_valid stable while out_valid=1 and out_ready=0.
REQ-028 SHALL drop no beat and duplicate no beat under any in_valid/out_ready pattern, and deliver beats in order.
REQ-029 SHALL, on simultaneous accept and emit with a full pipe, shift all stages in the same cycle.

Reset
REQ-030 SHALL, with rst=1 at a clock edge, clear all stage valids; out_valid=0 and result=0 the following cycle; in-flight beats are discarded.
REQ-031 SHALL drive in_ready=0 while rst=1 and in_ready=1 in the first cycle after rst deasserts.

Structure
REQ-032 SHALL place the coefficient index enum, the coefficient value table and the OUT_W offset (7) in shared package dct_pkg.
REQ-033 SHALL instantiate per-lane datapath sub-module dct_cmult_lane (stage registers and shared-handshake enables from the parent) LANES times via generate.

Verification
REQ-034 SHALL check SIZE=8, lane0 mcand=-128, sel=3, neg=0, approx_en=0 -> result -5760 exactly 3 cycles after accept.
REQ-035 SHALL check mcand=127 with sel=0 -> 8128; mcand=100, sel=1, neg=1 -> -6000; mcand=-5, sel=7 -> -5.
REQ-036 SHALL check APPROX_BITS=4, approx_en=1, mcand=3, sel=6 -> 28 (exact 36), and mcand=1, sel=6 -> 12.
REQ-037 SHALL stream 20 back-to-back beats with out_ready low for 4 cycles mid-stream -> all 20 results in order, result stable during the stall, in_ready low once the pipe is full.
REQ-038 SHALL assert rst with 3 beats in flight -> out_valid=0 next cycle, none of the 3 beats emitted, and the next accepted beat emerges with 3-cycle latency.
REQ-039 SHALL check LANES=8 random sel/neg/mcand per lane for 10^4 beats with random backpressure against a behavioural model -> zero mismatches.
